mem_bus_arbiter: RTL

//  N-master to single-port memory arbiter for the multi-cycle Yu Core system.

---
 rtl/mem_bus_arbiter_pkg.sv | 19 +
 rtl/mem_bus_arbiter_picker.sv | 48 ++++
 rtl/mem_bus_arbiter.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the memory bus arbiter: FSM state encoding, policy selectors, width helper.
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    localparam int RR_FIXED = 0;
    localparam int RR_ROUND = 1;

    // Index/counter width that never collapses to zero bits.
    function automatic int clog2_min1(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_picker.sv
// Purpose: pick one requester, round-robin after `last` or fixed priority (index 0 highest).
// Latency: purely combinational.
// Backpressure: none; grant is all-zero when no request is present.
module rr_priority_picker
    import mem_bus_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int RR_MODE     = RR_ROUND,
    localparam int IW         = clog2_min1(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [IW-1:0]          last,
    output logic [NUM_MASTERS-1:0] grant,
    output logic [IW-1:0]          grant_idx,
    output logic                   any
);

    localparam logic [IW:0] NUM = (IW+1)'(NUM_MASTERS);

    logic [IW:0]   sum;
    logic [IW-1:0] cand;
    logic          found;

    // last < N and the offset is at most N, so one conditional subtract is a full modulo.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        sum       = '0;
        cand      = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (RR_MODE == RR_ROUND) begin
                sum  = {1'b0, last} + (IW+1)'(k + 1);
                cand = (sum >= NUM) ? IW'(sum - NUM) : IW'(sum);
            end else begin
                cand = IW'(k);
            end
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Purpose: N-master to single-port memory arbiter; optional perf counters under ARB_PERF_CNT_EN.
// Latency: accept T, mem_en T+1, rsp_valid T+2+WAIT_STATES; next accept no earlier than T+WAIT_STATES+3.
// Backpressure: req_ready only in IDLE (one-hot to the winner); losers and busy cycles see ready=0.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int ADDR_W      = 32,
    parameter int NUM_MASTERS = 2,
    parameter int WAIT_STATES = 1,
    parameter int RR_MODE     = RR_ROUND
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_MASTERS-1:0]        req_valid,
    output logic [NUM_MASTERS-1:0]        req_ready,
    input  logic [NUM_MASTERS-1:0]        req_we,
    input  logic [NUM_MASTERS*ADDR_W-1:0] req_addr,
    input  logic [NUM_MASTERS*XLEN-1:0]   req_wdata,
    output logic [NUM_MASTERS-1:0]        rsp_valid,
    output logic [XLEN-1:0]               rsp_rdata,
    output logic                          mem_en,
    output logic                          mem_we,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [XLEN-1:0]               mem_wdata,
    input  logic [XLEN-1:0]               mem_rdata,
    output logic [NUM_MASTERS*32-1:0]     perf_grant,
    output logic [NUM_MASTERS*32-1:0]     perf_stall
);

    localparam int IW = clog2_min1(NUM_MASTERS);
    localparam int CW = clog2_min1(WAIT_STATES);

    arb_state_t             state, state_nxt;
    logic [IW-1:0]          last, gnt_idx, cur;
    logic [NUM_MASTERS-1:0] gnt_oh;
    logic                   any_req, accept, lat_we, sel_we;
    logic [CW-1:0]          wait_cnt;
    logic [XLEN-1:0]        rdata_q, sel_wdata;
    logic [ADDR_W-1:0]      sel_addr;

    rr_priority_picker #(
        .NUM_MASTERS(NUM_MASTERS),
        .RR_MODE    (RR_MODE)
    ) u_picker (
        .req      (req_valid),
        .last     (last),
        .grant    (gnt_oh),
        .grant_idx(gnt_idx),
        .any      (any_req)
    );

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_we    = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (gnt_oh[i]) begin
                sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata[i*XLEN +: XLEN];
                sel_we    = req_we[i];
            end
        end
    end

    // Ready is masked while rst is low so nothing looks accepted on a reset edge.
    always_comb begin
        state_nxt = state;
        req_ready = '0;
        rsp_valid = '0;
        rsp_rdata = '0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        unique case (state)
            IDLE: begin
                if (any_req && rst) begin
                    req_ready = gnt_oh;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                mem_en    = 1'b1;
                mem_we    = lat_we;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (wait_cnt == '0) state_nxt = RESP;
            end
            RESP: begin
                rsp_valid[cur] = 1'b1;
                rsp_rdata      = rdata_q;
                state_nxt      = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign accept = |req_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            last      <= IW'(NUM_MASTERS - 1);
            cur       <= '0;
            lat_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            wait_cnt  <= '0;
            rdata_q   <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cur       <= gnt_idx;
                last      <= gnt_idx;
                lat_we    <= sel_we;
                mem_addr  <= sel_addr;
                mem_wdata <= sel_wdata;
            end
            if (state == ISSUE) begin
                wait_cnt <= CW'(WAIT_STATES - 1);
            end else if (state == WAIT && wait_cnt != '0) begin
                wait_cnt <= wait_cnt - 1'b1;
            end
            // Writes return zero as their acknowledge data.
            if (state == WAIT && wait_cnt == '0) begin
                rdata_q <= lat_we ? '0 : mem_rdata;
            end
        end
    end

`ifdef ARB_PERF_CNT_EN
    logic [31:0] grant_cnt [NUM_MASTERS];
    logic [31:0] stall_cnt [NUM_MASTERS];

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (!rst) begin
                grant_cnt[i] <= '0;
                stall_cnt[i] <= '0;
            end else begin
                if (req_ready[i]) grant_cnt[i] <= grant_cnt[i] + 32'd1;
                if (req_valid[i] && !req_ready[i]) stall_cnt[i] <= stall_cnt[i] + 32'd1;
            end
        end
    end

    for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_perf
        assign perf_grant[i*32 +: 32] = grant_cnt[i];
        assign perf_stall[i*32 +: 32] = stall_cnt[i];
    end
`else
    assign perf_grant = '0;
    assign perf_stall = '0;
`endif

endmodule
